// File: rtl/simple_processor_pkg.sv
// Shared types for the multi-cycle execution unit: operation encodings,
// FSM states and the default datapath width.
package simple_processor_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  // Encodings 14 and 15 are unassigned and complete as single-cycle ops with a zero result.
  typedef enum logic [3:0] {
    FUNC_ADD  = 4'd0,
    FUNC_ADDI = 4'd1,
    FUNC_SUB  = 4'd2,
    FUNC_AND  = 4'd3,
    FUNC_OR   = 4'd4,
    FUNC_XOR  = 4'd5,
    FUNC_NOT  = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10,
    FUNC_SRA  = 4'd11,
    FUNC_SRAI = 4'd12,
    FUNC_MUL  = 4'd13
  } func_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } exec_state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Shift-and-add multiplier, one multiplier bit per cycle. done is high during
// the final step and product already includes that step's partial sum.
module exec_mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mlier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic [CW-1:0]         count;

  assign acc_sum = acc + (mlier[0] ? mcand : '0);
  assign done    = (count == CW'(1));
  assign product = acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mlier <= '0;
      acc   <= '0;
      count <= '0;
    end else if (start) begin
      mcand <= multiplicand;
      mlier <= multiplier;
      acc   <= '0;
      count <= CW'(DATA_WIDTH);
    end else if (count != '0) begin
      acc   <= acc_sum;
      mcand <= mcand << 1;
      mlier <= mlier >> 1;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Execution unit: single-cycle ALU ops plus an iterative multiply, behind a
// registered result stage with valid/ready flow control.
module exec_unit_mc
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMM_WIDTH  = 6,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  func_t                 func_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [IMM_WIDTH-1:0]  imm_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  busy_o,
  output exec_state_t           state_o
);

  // Handshake: a request is taken on a rising edge where valid_i && ready_o;
  // a result is consumed on a rising edge where valid_o && ready_i.
  localparam int SHW = $clog2(DATA_WIDTH);

  exec_state_t           state, state_next;
  logic                  accept, load_alu, start_mul, mul_done;
  logic [DATA_WIDTH-1:0] alu_result, mul_product, imm_ext;
  logic [DATA_WIDTH-1:0] result_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [SHW-1:0]        shamt_reg, shamt_imm;

  assign imm_ext   = DATA_WIDTH'($signed(imm_i));
  assign shamt_reg = rs2_data_i[SHW-1:0];
  assign shamt_imm = SHW'(imm_i);

  always_comb begin
    alu_result = '0;
    case (func_i)
      FUNC_ADD:  alu_result = rs1_data_i + rs2_data_i;
      FUNC_ADDI: alu_result = rs1_data_i + imm_ext;
      FUNC_SUB:  alu_result = rs1_data_i - rs2_data_i;
      FUNC_AND:  alu_result = rs1_data_i & rs2_data_i;
      FUNC_OR:   alu_result = rs1_data_i | rs2_data_i;
      FUNC_XOR:  alu_result = rs1_data_i ^ rs2_data_i;
      FUNC_NOT:  alu_result = ~rs1_data_i;
      FUNC_SLL:  alu_result = rs1_data_i << shamt_reg;
      FUNC_SLLI: alu_result = rs1_data_i << shamt_imm;
      FUNC_SLR:  alu_result = rs1_data_i >> shamt_reg;
      FUNC_SLRI: alu_result = rs1_data_i >> shamt_imm;
      FUNC_SRA:  alu_result = $signed(rs1_data_i) >>> shamt_reg;
      FUNC_SRAI: alu_result = $signed(rs1_data_i) >>> shamt_imm;
      default:   alu_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    load_alu   = 1'b0;
    start_mul  = 1'b0;
    case (state)
      ST_IDLE: ready_o = 1'b1;
      ST_MUL:  if (mul_done) state_next = ST_OUT;
      ST_OUT: begin
        ready_o = ready_i;
        if (ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    accept = valid_i && ready_o;
    if (accept) begin
      if (func_i == FUNC_MUL) begin
        start_mul  = 1'b1;
        state_next = ST_MUL;
      end else begin
        load_alu   = 1'b1;
        state_next = ST_OUT;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= ST_IDLE;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state <= state_next;
      if (load_alu) begin
        result_q <= alu_result;
        tag_q    <= tag_i;
      end else if (start_mul) begin
        tag_q <= tag_i;
      end else if (state == ST_MUL && mul_done) begin
        result_q <= mul_product;
      end
    end
  end

  exec_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk          (clk_i),
    .rst          (arst_i),
    .start        (start_mul),
    .multiplicand (rs1_data_i),
    .multiplier   (rs2_data_i),
    .done         (mul_done),
    .product      (mul_product)
  );

  assign valid_o  = (state == ST_OUT);
  assign busy_o   = (state == ST_MUL);
  assign result_o = result_q;
  assign tag_o    = tag_q;
  assign state_o  = state;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: vector table for single-cycle ops, then
// hand-written multiply, backpressure and reset-in-flight sequences.
module tb_exec_unit_mc;
  import simple_processor_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  func_t       func = FUNC_ADD;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [5:0]  imm = '0;
  logic [4:0]  tag = '0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic        busy;
  exec_state_t state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    func_t       func;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  exec_unit_mc dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
    .func_i     (func),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .imm_i      (imm),
    .tag_i      (tag),
    .valid_o    (valid_out),
    .ready_i    (ready_in),
    .result_o   (result),
    .tag_o      (tag_out),
    .busy_o     (busy),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input func_t f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] im, input logic [4:0] t);
    valid_in = 1'b1;
    func = f;
    rs1 = a;
    rs2 = b;
    imm = im;
    tag = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_valid;

    vecs[0]  = '{FUNC_ADD,  32'd5,        32'd7,      6'd0,       5'd3,  32'd12};
    vecs[1]  = '{FUNC_ADDI, 32'd10,       32'd0,      6'b111110,  5'd1,  32'd8};
    vecs[2]  = '{FUNC_SUB,  32'd5,        32'd7,      6'd0,       5'd2,  32'hFFFF_FFFE};
    vecs[3]  = '{FUNC_AND,  32'h0000_F0F0, 32'h0000_FF00, 6'd0,   5'd4,  32'h0000_F000};
    vecs[4]  = '{FUNC_OR,   32'h0000_F0F0, 32'h0000_FF00, 6'd0,   5'd5,  32'h0000_FFF0};
    vecs[5]  = '{FUNC_XOR,  32'h0000_F0F0, 32'h0000_FF00, 6'd0,   5'd6,  32'h0000_0FF0};
    vecs[6]  = '{FUNC_NOT,  32'h0000_0000, 32'd0,     6'd0,       5'd7,  32'hFFFF_FFFF};
    vecs[7]  = '{FUNC_SRA,  32'h8000_0000, 32'h24,    6'd0,       5'd8,  32'hF800_0000};
    vecs[8]  = '{FUNC_SLR,  32'h8000_0000, 32'h24,    6'd0,       5'd9,  32'h0800_0000};
    vecs[9]  = '{FUNC_SLL,  32'd1,        32'h21,     6'd0,       5'd10, 32'd2};
    vecs[10] = '{FUNC_SLLI, 32'd1,        32'd0,      6'd31,      5'd11, 32'h8000_0000};
    vecs[11] = '{FUNC_SRAI, 32'h8000_0000, 32'd0,     6'd63,      5'd12, 32'hFFFF_FFFF};
    vecs[12] = '{FUNC_SLRI, 32'h8000_0000, 32'd0,     6'd31,      5'd13, 32'd1};
    vecs[13] = '{func_t'(4'd14), 32'hDEAD_BEEF, 32'h1234, 6'd5,   5'd14, 32'd0};
    vecs[14] = '{func_t'(4'd15), 32'hFFFF_FFFF, 32'hFFFF, 6'd63,  5'd15, 32'd0};

    // Reset values, asynchronous (no clock edge yet)
    #2;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag", 32'(tag_out), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    arst = 1'b0;
    check("idle_ready", 32'(ready_out), 32'd1);

    // Single-cycle ops back to back; first accept on first edge after release
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].func, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].tag);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'd1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), 32'(tag_out), 32'(vecs[i].tag));
      check($sformatf("vec%0d_ready", i), 32'(ready_out), 32'd1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    tick();
    check("drain_valid", 32'(valid_out), 32'd0);

    // Multiply: 0xFFFFFFFF * 3, 32 busy cycles with stray requests
    @(negedge clk);
    drive(FUNC_MUL, 32'hFFFF_FFFF, 32'd3, 6'd0, 5'd7);
    tick();
    for (int i = 0; i < 32; i++) begin
      check($sformatf("mul_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("mul_ready%0d", i), 32'(ready_out), 32'd0);
      check($sformatf("mul_valid%0d", i), 32'(valid_out), 32'd0);
      @(negedge clk);
      drive(FUNC_ADD, 32'(i), 32'd1, 6'd0, 5'd1);
      valid_in = (i < 31) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    check("mul_done_valid", 32'(valid_out), 32'd1);
    check("mul_done_busy", 32'(busy), 32'd0);
    check("mul_result", result, 32'hFFFF_FFFD);
    check("mul_tag", 32'(tag_out), 32'd7);
    @(negedge clk);
    tick();
    check("mul_drain_valid", 32'(valid_out), 32'd0);

    // Backpressure: hold result for 5 cycles, then 4 back-to-back ADDs
    @(negedge clk);
    ready_in = 1'b0;
    drive(FUNC_ADD, 32'd20, 32'd22, 6'd0, 5'd9);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(valid_out), 32'd1);
      check($sformatf("stall%0d_result", i), result, 32'd42);
      check($sformatf("stall%0d_tag", i), 32'(tag_out), 32'd9);
      check($sformatf("stall%0d_ready", i), 32'(ready_out), 32'd0);
      @(negedge clk);
      drive(FUNC_SUB, 32'd99, 32'(i), 6'd0, 5'd30);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ready_in = 1'b1;
      drive(FUNC_ADD, 32'(k), 32'd100, 6'd0, 5'(k + 16));
      tick();
      check($sformatf("b2b%0d_valid", k), 32'(valid_out), 32'd1);
      check($sformatf("b2b%0d_result", k), result, 32'(k + 100));
      check($sformatf("b2b%0d_tag", k), 32'(tag_out), 32'(k + 16));
    end
    @(negedge clk);
    valid_in = 1'b0;
    tick();
    check("b2b_drain_valid", 32'(valid_out), 32'd0);

    // Reset 10 cycles into a multiply discards it
    @(negedge clk);
    drive(FUNC_MUL, 32'd6, 32'd7, 6'd0, 5'd4);
    tick();
    @(negedge clk);
    valid_in = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(valid_out), 32'd0);
    check("async_rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_out !== 1'b0 || busy !== 1'b0) seen_valid++;
    end
    check("post_rst_no_result", 32'(seen_valid), 32'd0);
    @(negedge clk);
    drive(FUNC_ADD, 32'd1, 32'd1, 6'd0, 5'd2);
    tick();
    check("post_rst_add_valid", 32'(valid_out), 32'd1);
    check("post_rst_add_result", result, 32'd2);
    check("post_rst_add_tag", 32'(tag_out), 32'd2);
    @(negedge clk);
    valid_in = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
